weight_sparse_dec: RTL

//  Decoder side of the weight sparse path: rebuilds dense COL-element weight columns from two inputs.

---
 rtl/weight_sparse_dec_pkg.sv | 13 +
 rtl/weight_sparse_dec_idx_cnt.sv | 29 ++
 rtl/weight_sparse_dec.sv | 90 +++++++++
 3 files changed

// File: rtl/weight_sparse_dec_pkg.sv
// Shared widths and FSM encoding for the sparse weight decoder path.
package weight_sparse_dec_pkg;

    localparam int unsigned DEF_DW  = 8;
    localparam int unsigned DEF_COL = 8;
    localparam int unsigned DEF_IW  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

endpackage

// File: rtl/weight_sparse_dec_idx_cnt.sv
// Element index counter within a column, with clear, increment and last-position flag.
module weight_sparse_dec_idx_cnt #(
    parameter int unsigned IW  = 3,
    parameter int unsigned COL = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          sys_en,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] idx,
    output logic          last
);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idx <= '0;
        end else if (sys_en) begin
            if (clr) begin
                idx <= '0;
            end else if (inc) begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign last = (idx == IW'(COL - 1));

endmodule

// File: rtl/weight_sparse_dec.sv
// Rebuilds dense weight columns from a zero bitmap plus a packed stream of non-zero elements.
module weight_sparse_dec
    import weight_sparse_dec_pkg::*;
#(
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned COL = DEF_COL,
    parameter int unsigned IW  = DEF_IW
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           sys_en,
    input  logic           map_valid,
    output logic           map_ready,
    input  logic [COL-1:0] map_in,
    input  logic           nz_valid,
    output logic           nz_ready,
    input  logic [DW-1:0]  nz_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_zero,
    output logic [IW-1:0]  out_idx,
    output logic           out_last,
    output logic           col_sparse
);

    state_t         state;
    logic [COL-1:0] map_reg;
    logic [IW-1:0]  idx;
    logic           idx_last;
    logic           slot_free;
    logic           step;
    logic           cur_zero;
    logic           load;
    logic           map_acc;

    weight_sparse_dec_idx_cnt #(
        .IW  (IW),
        .COL (COL)
    ) u_idx_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sys_en  (sys_en),
        .clr     (map_acc),
        .inc     (load),
        .idx     (idx),
        .last    (idx_last)
    );

    // Handshakes are suppressed during reset so a reset cycle consumes nothing.
    assign slot_free = !out_valid || out_ready;
    assign cur_zero  = map_reg[idx];
    assign step      = !sys_rst && sys_en && (state == ST_EXPAND) && slot_free;
    assign nz_ready  = step && !cur_zero && nz_valid;
    assign load      = step && (cur_zero || nz_valid);
    assign map_ready = !sys_rst && sys_en && (state == ST_IDLE);
    assign map_acc   = map_valid && map_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            map_reg    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            col_sparse <= 1'b0;
        end else if (sys_en) begin
            if (map_acc) begin
                state      <= ST_EXPAND;
                map_reg    <= map_in;
                col_sparse <= &map_in;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= cur_zero ? '0 : nz_data;
                out_zero  <= cur_zero;
                out_idx   <= idx;
                out_last  <= idx_last;
                if (idx_last) begin
                    state <= ST_IDLE;
                end
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
